// File: rtl/multicycle_control_unit_if.sv
// Control-unit boundary: instruction fields, flags and memory handshake in; datapath mux selects and enables out.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int TIPO_W   = 2,
  parameter int OP_W     = 2,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 32
);
  logic [TIPO_W-1:0]   tipo;
  logic [OP_W-1:0]     op;
  logic                Inm;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_write;
  logic                adr_src;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic [1:0]          imm_src;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          result_src;
  logic [ALUCTL_W-1:0] alu_control;
  logic                illegal;
  logic [3:0]          state_dbg;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  tipo, op, Inm, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           imm_src, alu_src_a, alu_src_b, result_src, alu_control,
           illegal, state_dbg, instr_count
  );

  modport slave (
    output tipo, op, Inm, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           imm_src, alu_src_a, alu_src_b, result_src, alu_control,
           illegal, state_dbg, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller sharing one memory port and ALU; CU_INSTR_COUNT_EN adds a retired-instruction counter.
// Latency 2..5 cycles per instruction; every mem_ready=0 cycle in FETCH/MEMRD/MEMWR holds the state one extra cycle.
module multicycle_control_unit #(
  parameter int TIPO_W   = 2,
  parameter int OP_W     = 2,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    EXEC_I = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);

  state_t state, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (bus.tipo == TIPO_W'(0))      nxt = bus.Inm ? EXEC_I : EXEC_R;
        else if (bus.tipo == TIPO_W'(1)) nxt = MEMADR;
        else if (bus.tipo == TIPO_W'(2)) nxt = BRANCH;
        else                             nxt = FETCH;
      end
      MEMADR: nxt = bus.op[0] ? MEMRD : MEMWR;
      MEMRD:  nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = bus.mem_ready ? FETCH : MEMWR;
      EXEC_R: nxt = ALUWB;
      EXEC_I: nxt = ALUWB;
      default: nxt = FETCH;
    endcase
  end

  // Enables that commit architectural state are masked while reset is held,
  // since the async reset parks the FSM in FETCH where mem_ready could fire them.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.adr_src     = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.imm_src     = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.result_src  = 2'b00;
    bus.alu_control = ALU_ADD;
    bus.illegal     = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready & ~rst;
        bus.pc_write   = bus.mem_ready & ~rst;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b10;
        bus.illegal   = (bus.tipo == TIPO_W'(3));
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b01;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      MEMWR: begin
        bus.mem_req   = 1'b1;
        bus.adr_src   = 1'b1;
        bus.mem_write = bus.mem_ready & ~rst;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = ~rst;
      end
      EXEC_R: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = ALUCTL_W'(bus.op);
      end
      EXEC_I: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = ALUCTL_W'(bus.op);
      end
      ALUWB: bus.reg_write = ~rst;
      BRANCH: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = ALU_SUB;
        bus.pc_write    = ~rst & ((bus.op == OP_W'(0)) | ((bus.op == OP_W'(1)) & bus.zero));
      end
      default: ;
    endcase
  end

  assign bus.state_dbg = state;

`ifdef CU_INSTR_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                  ((state == MEMWR) && bus.mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (retire) cnt <= cnt + CNT_W'(1);
  end

  assign bus.instr_count = cnt;
`else
  assign bus.instr_count = '0;
`endif

endmodule
